// File: rtl/line_window_3row.sv
// rtl/line_window_3row.sv - raster-to-column 3-row window generator feeding the vertical gauss stage
// Two line buffers hold rows r-1 and r-2; each accepted pixel emits a vertically aligned triple one cycle later.
module line_window_3row #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = 6,
  parameter int ROW_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [7:0]       out0,
  output logic [7:0]       out1,
  output logic [7:0]       out2,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_eol,
  output logic             out_eof,
  output logic             sof_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] FIRST_WINDOW_ROW = ROW_W'(2);

  logic [7:0]       r_lb_a [IMG_WIDTH];
  logic [7:0]       r_lb_b [IMG_WIDTH];
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic [7:0]       r_out0;
  logic [7:0]       r_out1;
  logic [7:0]       r_out2;
  logic             r_out_valid;
  logic [COL_W-1:0] r_out_col;
  logic [ROW_W-1:0] r_out_row;
  logic             r_out_eol;
  logic             r_out_eof;
  logic             r_sof_err;

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_last_col;
  logic             w_last_row;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_not_origin;

  // sof forces the pixel to (0,0); everything downstream uses the effective position
  always_comb begin
    w_col        = sof ? '0 : r_col;
    w_row        = sof ? '0 : r_row;
    w_last_col   = (w_col == LAST_COL);
    w_last_row   = (w_row == LAST_ROW);
    w_not_origin = (r_col != '0) || (r_row != '0);
    w_col_nxt    = w_col + COL_W'(1);
    w_row_nxt    = w_row;
    if (w_last_col) begin
      w_col_nxt = '0;
      w_row_nxt = w_last_row ? '0 : w_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_sof_err   <= 1'b0;
    end else if (pix_valid) begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_out2      <= pix_in;
      r_out1      <= r_lb_a[w_col];
      r_out0      <= r_lb_b[w_col];
      r_out_col   <= w_col;
      r_out_row   <= w_row;
      r_out_valid <= (w_row >= FIRST_WINDOW_ROW);
      r_out_eol   <= w_last_col;
      r_out_eof   <= w_last_col && w_last_row;
      r_sof_err   <= sof && w_not_origin;
    end else begin
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_sof_err   <= 1'b0;
    end
  end

  // Line buffers are never cleared; rows 0 and 1 refill them before any window is flagged valid
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) begin
      r_lb_b[w_col] <= r_lb_a[w_col];
      r_lb_a[w_col] <= pix_in;
    end
  end

  assign out0      = r_out0;
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign out_valid = r_out_valid;
  assign out_col   = r_out_col;
  assign out_row   = r_out_row;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;
  assign sof_err   = r_sof_err;

endmodule
